// File: rtl/plru_set_ctrl_if.sv
// Access bus between the tag-compare stage and the per-set PLRU controller.
//   master : upstream stage, drives req_* and observes ready/response/init_busy
//   slave  : plru_set_ctrl, drives req_ready, resp_* and init_busy
//   req_valid/req_ready : one access per cycle when both are high
//   req_set/req_hit/req_way/req_vld_ways : access description
//   resp_valid/resp_set/resp_way : one-cycle response per accepted access
//   init_busy : state array sweep in progress
interface plru_set_ctrl_if #(
    parameter int SET_BITS = 6,
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [SET_BITS-1:0] req_set;
    logic                req_hit;
    logic [WAYS_REP-1:0] req_way;
    logic [WAYS-1:0]     req_vld_ways;
    logic                resp_valid;
    logic [SET_BITS-1:0] resp_set;
    logic [WAYS_REP-1:0] resp_way;
    logic                init_busy;

    modport master (
        output req_valid, req_set, req_hit, req_way, req_vld_ways,
        input  req_ready, resp_valid, resp_set, resp_way, init_busy
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_way, req_vld_ways,
        output req_ready, resp_valid, resp_set, resp_way, init_busy
    );
endinterface

// File: rtl/plru_set_ctrl.sv
// Per-set 8-way tree-PLRU state store and victim selector.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (restarts the array sweep)
//   bus  : plru_set_ctrl_if.slave access/response bus
// Pipeline: accept edge registers the request and the synchronous array read;
// the following cycle computes victim/new bits, and its closing edge writes the
// array and registers the response.
module plru_set_ctrl #(
    parameter int NUM_SETS = 64,
    parameter int SET_BITS = $clog2(NUM_SETS),
    parameter int WAYS     = 8,
    parameter int WAYS_REP = $clog2(WAYS)
) (
    input  logic           clk,
    input  logic           rst,
    plru_set_ctrl_if.slave bus
);
    localparam int TREE_BITS = WAYS - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state_q, state_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic init_busy, req_ready, accept;

    logic                 s1_valid_q, s1_valid_d;
    logic [SET_BITS-1:0]  s1_set_q, s1_set_d;
    logic                 s1_hit_q, s1_hit_d;
    logic [WAYS_REP-1:0]  s1_way_q, s1_way_d;
    logic [WAYS-1:0]      s1_vld_q, s1_vld_d;
    logic                 fwd_q, fwd_d;
    logic [TREE_BITS-1:0] fwd_bits_q, fwd_bits_d;
    logic [TREE_BITS-1:0] rd_bits_q;

    logic                 resp_valid_q, resp_valid_d;
    logic [SET_BITS-1:0]  resp_set_q, resp_set_d;
    logic [WAYS_REP-1:0]  resp_way_q, resp_way_d;

    logic [TREE_BITS-1:0] cur_bits, new_bits, mem_wdata;
    logic [WAYS_REP-1:0]  low_inv, victim, touch;
    logic [SET_BITS-1:0]  mem_waddr;
    logic                 mem_we;

    logic [TREE_BITS-1:0] mem_q [NUM_SETS];

    // Walk from the root against each MRU pointer.
    function automatic logic [2:0] tree_victim(input logic [6:0] b);
        logic [2:0] v;
        v[2] = ~b[0];
        v[1] = v[2] ? ~b[2] : ~b[1];
        case ({v[2], v[1]})
            2'd0:    v[0] = ~b[3];
            2'd1:    v[0] = ~b[4];
            2'd2:    v[0] = ~b[5];
            default: v[0] = ~b[6];
        endcase
        return v;
    endfunction

    // Point the three path bits of way w at w; leave the rest alone.
    function automatic logic [6:0] tree_update(input logic [6:0] b, input logic [2:0] w);
        logic [6:0] n;
        n    = b;
        n[0] = w[2];
        if (w[2]) n[2] = w[1];
        else      n[1] = w[1];
        case (w[2:1])
            2'd0:    n[3] = w[0];
            2'd1:    n[4] = w[0];
            2'd2:    n[5] = w[0];
            default: n[6] = w[0];
        endcase
        return n;
    endfunction

    // Sweep / run control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == SET_BITS'(NUM_SETS - 1)) state_d = ST_RUN;
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept = bus.req_valid & req_ready;

    // Lowest-index invalid line wins over the tree when the set is not full.
    always_comb begin
        low_inv = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!s1_vld_q[i]) low_inv = WAYS_REP'(i);
        end
    end

    always_comb begin
        // A back-to-back access to the same set read the array before the
        // previous access's write landed, so take the bits it computed instead.
        cur_bits = fwd_q ? fwd_bits_q : rd_bits_q;
        victim   = (&s1_vld_q) ? tree_victim(cur_bits) : low_inv;
        touch    = s1_hit_q ? s1_way_q : victim;
        new_bits = tree_update(cur_bits, touch);

        s1_valid_d = accept;
        s1_set_d   = accept ? bus.req_set : s1_set_q;
        s1_hit_d   = accept ? bus.req_hit : s1_hit_q;
        // Don't-care inputs are replaced by constants so they never reach the array.
        s1_way_d   = accept ? (bus.req_hit ? bus.req_way : '0) : s1_way_q;
        s1_vld_d   = accept ? (bus.req_hit ? '1 : bus.req_vld_ways) : s1_vld_q;
        fwd_d      = accept & s1_valid_q & (bus.req_set == s1_set_q);
        fwd_bits_d = new_bits;

        resp_valid_d = s1_valid_q;
        resp_set_d   = s1_valid_q ? s1_set_q : resp_set_q;
        resp_way_d   = s1_valid_q ? touch : resp_way_q;

        mem_we    = ~rst & (init_busy | s1_valid_q);
        mem_waddr = init_busy ? cnt_q : s1_set_q;
        mem_wdata = init_busy ? '0 : new_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_set_q     <= '0;
            s1_hit_q     <= 1'b0;
            s1_way_q     <= '0;
            s1_vld_q     <= '1;
            fwd_q        <= 1'b0;
            fwd_bits_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_set_q   <= '0;
            resp_way_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_set_q     <= s1_set_d;
            s1_hit_q     <= s1_hit_d;
            s1_way_q     <= s1_way_d;
            s1_vld_q     <= s1_vld_d;
            fwd_q        <= fwd_d;
            fwd_bits_q   <= fwd_bits_d;
            resp_valid_q <= resp_valid_d;
            resp_set_q   <= resp_set_d;
            resp_way_q   <= resp_way_d;
        end
    end

    // State array: one write port, registered read on accept.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (accept) rd_bits_q <= mem_q[bus.req_set];
    end

    assign bus.req_ready  = req_ready;
    assign bus.init_busy  = init_busy;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_set   = resp_set_q;
    assign bus.resp_way   = resp_way_q;
endmodule

// File: tb/tb_plru_set_ctrl.sv
module tb_plru_set_ctrl;
    localparam int NS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plru_set_ctrl_if #(.SET_BITS(6), .WAYS(8), .WAYS_REP(3)) bus ();

    plru_set_ctrl #(.NUM_SETS(NS), .SET_BITS(6), .WAYS(8), .WAYS_REP(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int set; int way; int due;} exp_t;
    exp_t expq[$];
    int last_way = -1;

    // Model: per-way last-touch time. A tree node prefers the half whose most
    // recent touch is older; untouched (time 0) subtrees tie toward the upper half.
    int ts [NS][8];
    int tnow;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < 8; w++) ts[s][w] = 0;
        tnow = 0;
    endtask

    function automatic int max_ts(input int s, input int lo, input int n);
        int m = 0;
        for (int k = lo; k < lo + n; k++) if (ts[s][k] > m) m = ts[s][k];
        return m;
    endfunction

    function automatic int model_victim(input int s, input logic [7:0] vld);
        int lo = 0;
        int size = 8;
        for (int k = 0; k < 8; k++) if (!vld[k]) return k;
        while (size > 1) begin
            int half = size / 2;
            if (!(max_ts(s, lo + half, half) > max_ts(s, lo, half))) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic do_req(input int s, input bit hit, input int w, input logic [7:0] vld,
                          output int exp_way);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_set      = 6'(s);
        bus.req_hit      = hit;
        bus.req_way      = 3'(w);
        bus.req_vld_ways = vld;
        exp_way = -1;
        if (bus.req_ready) begin
            exp_way = hit ? w : model_victim(s, vld);
            tnow++;
            ts[s][exp_way] = tnow;
            expq.push_back('{s, exp_way, cyc + 2});
            $display("req set=%0d hit=%0d way=%0d vld=%h -> expect way %0d", s, hit, w, vld, exp_way);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    // Release reset (if held) and measure the sweep; requests offered meanwhile must be ignored.
    task automatic wait_init(input string tag);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_set = 6'd1;
        bus.req_hit = 1'b0;
        bus.req_vld_ways = 8'hFF;
        for (int i = 0; i < 200 && bus.init_busy; i++) begin
            n++;
            if (bus.req_ready) bad++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk({tag, "_busy_cycles"}, n, NS);
        chk({tag, "_ready_in_init"}, bad, 0);
        chk({tag, "_ready_after"}, int'(bus.req_ready), 1);
        chk({tag, "_busy_after"}, int'(bus.init_busy), 0);
    endtask

    // Compare process: every cycle, either a response is due or resp_valid must be low.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("resp_valid", int'(bus.resp_valid), 1);
                chk("resp_set", int'(bus.resp_set), expq[0].set);
                chk("resp_way", int'(bus.resp_way), expq[0].way);
                $display("resp set=%0d way=%0d (expected set=%0d way=%0d)",
                         bus.resp_set, bus.resp_way, expq[0].set, expq[0].way);
                last_way = int'(bus.resp_way);
                void'(expq.pop_front());
            end else begin
                chk("resp_idle", int'(bus.resp_valid), 0);
            end
        end
    end

    int e;
    int rot[8] = '{7, 3, 5, 1, 6, 2, 4, 0};

    initial begin
        bus.req_valid = 1'b0;
        bus.req_set = '0;
        bus.req_hit = 1'b0;
        bus.req_way = '0;
        bus.req_vld_ways = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_busy", int'(bus.init_busy), 1);
        chk("rst_resp_set", int'(bus.resp_set), 0);
        chk("rst_resp_way", int'(bus.resp_way), 0);

        // 1. sweep
        wait_init("init");

        // 2. first miss on a clean set, then confirm bits 1000101 via next victim
        do_req(5, 0, 0, 8'hFF, e); chk("t2_model", e, 7);
        idle(3); chk("t2_dut", last_way, 7);
        do_req(5, 0, 0, 8'hFF, e); chk("t2_next_model", e, 3);
        idle(3); chk("t2_next_dut", last_way, 3);

        // 3. hit then miss back-to-back (forwarding)
        do_req(3, 1, 7, 8'hFF, e);
        do_req(3, 0, 0, 8'hFF, e); chk("t3_model", e, 3);
        idle(3); chk("t3_dut", last_way, 3);

        // 4. invalid-way override, then tree after override (bits 0000010)
        do_req(9, 0, 0, 8'b1111_1011, e); chk("t4_model", e, 2);
        idle(3); chk("t4_dut", last_way, 2);
        do_req(9, 0, 0, 8'hFF, e); chk("t4_next_model", e, 7);
        idle(3); chk("t4_next_dut", last_way, 7);

        // 5. full rotation, 8 consecutive misses
        for (int i = 0; i < 8; i++) begin
            do_req(1, 0, 0, 8'hFF, e);
            chk($sformatf("t5_rot%0d", i), e, rot[i]);
        end
        idle(3); chk("t5_dut_last", last_way, 0);

        // mixed burst: same-set streaks with hits, misses and overrides
        for (int i = 0; i < 16; i++) begin
            do_req((i < 8) ? 12 : ((i % 2 == 1) ? 13 : 12), (i % 3 == 1), i % 8,
                   (i == 5) ? 8'h7F : ((i == 11) ? 8'hF0 : 8'hFF), e);
        end
        idle(3);

        // 6. reset with requests in flight
        do_req(20, 0, 0, 8'hFF, e);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_set = 6'd20;
        rst = 1'b1;
        expq.delete();
        model_reset();
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_init("reinit");
        do_req(1, 0, 0, 8'hFF, e); chk("t6_set1_model", e, 7);
        do_req(5, 0, 0, 8'hFF, e); chk("t6_set5_model", e, 7);
        do_req(20, 0, 0, 8'hFF, e); chk("t6_set20_model", e, 7);
        idle(3); chk("t6_dut", last_way, 7);

        idle(4);
        chk("drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
